// File: rtl/multisim_loopback_fifo_if.sv
// multisim_loopback_fifo_if: pull-to-push handshake and debug status bundle
interface multisim_loopback_fifo_if #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_WIDTH = 32
);
  logic in_rdy;
  logic in_vld;
  logic [DATA_WIDTH-1:0] in_data;
  logic out_vld;
  logic out_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_WIDTH-1:0] rx_count;
  logic [CNT_WIDTH-1:0] tx_count;
  logic err;
  modport master (
    input in_rdy, out_vld, out_data, level, rx_count, tx_count, err,
    output in_vld, in_data, out_rdy
  );
  modport slave (
    output in_rdy, out_vld, out_data, level, rx_count, tx_count, err,
    input in_vld, in_data, out_rdy
  );
endinterface

// File: rtl/multisim_loopback_fifo.sv
// multisim_loopback_fifo: FWFT buffer between pull and push servers with debug counters
module multisim_loopback_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  multisim_loopback_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level;
  logic [CNT_WIDTH-1:0] rx_count, tx_count;
  logic err, wr, rd;
  assign bus.in_rdy = level != (AW+1)'(DEPTH);
  assign bus.out_vld = level != '0;
  assign bus.out_data = mem[rd_ptr];
  assign bus.level = level;
  assign bus.rx_count = rx_count;
  assign bus.tx_count = tx_count;
  assign bus.err = err;
  assign wr = bus.in_vld && bus.in_rdy;
  assign rd = bus.out_vld && bus.out_rdy;
  always_ff @(posedge clk)
    if (rst_n && wr) mem[wr_ptr] <= bus.in_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rx_count <= '0;
      tx_count <= '0;
      err <= 1'b0;
    end else begin
      level <= level + (AW+1)'(wr) - (AW+1)'(rd);
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      if (wr) rx_count <= rx_count + CNT_WIDTH'(1);
      if (rd) tx_count <= tx_count + CNT_WIDTH'(1);
      if (bus.in_vld && !bus.in_rdy) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_multisim_loopback_fifo.sv
// tb_multisim_loopback_fifo: scoreboard bench for the loopback FIFO (4-bit counters to exercise wrap)
module tb_multisim_loopback_fifo;
  localparam int DW = 64;
  localparam int DEPTH = 4;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mon_on = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q [$];
  int m_level = 0;
  logic [CW-1:0] m_rx = '0, m_tx = '0;
  logic m_err = 1'b0;
  multisim_loopback_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) bus ();
  multisim_loopback_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // model checks current outputs, then predicts the next posedge from the stable inputs
  always @(negedge clk) begin
    if (mon_on) begin
      chk("level", 64'(bus.level), 64'(m_level));
      chk("in_rdy", 64'(bus.in_rdy), 64'(m_level != DEPTH));
      chk("out_vld", 64'(bus.out_vld), 64'(m_level != 0));
      chk("rx_count", 64'(bus.rx_count), 64'(m_rx));
      chk("tx_count", 64'(bus.tx_count), 64'(m_tx));
      chk("err", 64'(bus.err), 64'(m_err));
    end
    if (!rst_n) begin
      exp_q.delete();
      m_level = 0;
      m_rx = '0;
      m_tx = '0;
      m_err = 1'b0;
    end else begin
      automatic bit mw = bus.in_vld && m_level != DEPTH;
      automatic bit mr = bus.out_rdy && m_level != 0;
      if (bus.in_vld && m_level == DEPTH) m_err = 1'b1;
      if (mr) begin
        if (exp_q.size() == 0) chk("scoreboard_empty", 64'(exp_q.size()), 64'd1);
        else chk("out_data", bus.out_data, exp_q.pop_front());
        m_tx++;
      end
      if (mw) begin
        exp_q.push_back(bus.in_data);
        m_rx++;
      end
      m_level = m_level + int'(mw) - int'(mr);
    end
  end
  initial begin
    bus.in_vld = 1'b1;
    bus.in_data = 64'hAAAA;
    bus.out_rdy = 1'b0;
    step();
    step();
    mon_on = 1'b1;
    rst_n = 1'b1;
    bus.in_vld = 1'b0;
    chk("rst_level", 64'(bus.level), 64'd0);
    chk("rst_out_vld", 64'(bus.out_vld), 64'd0);
    chk("rst_in_rdy", 64'(bus.in_rdy), 64'd1);
    bus.in_vld = 1'b1;
    bus.in_data = 64'hDEADBEEF_00000001;
    bus.out_rdy = 1'b1;
    step();
    bus.in_vld = 1'b0;
    chk("single_vld", 64'(bus.out_vld), 64'd1);
    chk("single_data", bus.out_data, 64'hDEADBEEF_00000001);
    step();
    chk("single_rx", 64'(bus.rx_count), 64'd1);
    chk("single_tx", 64'(bus.tx_count), 64'd1);
    chk("single_level", 64'(bus.level), 64'd0);
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_vld = 1'b1;
      bus.in_data = 64'(i);
      step();
    end
    chk("full_in_rdy", 64'(bus.in_rdy), 64'd0);
    chk("full_level", 64'(bus.level), 64'd4);
    bus.in_data = 64'h55;
    step();
    chk("err_set", 64'(bus.err), 64'd1);
    chk("err_rx", 64'(bus.rx_count), 64'd5);
    bus.in_vld = 1'b0;
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", bus.out_data, 64'(i));
      step();
      if (i == 0) chk("drain_in_rdy", 64'(bus.in_rdy), 64'd1);
    end
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_vld = 1'b1;
      bus.in_data = 64'h200 + 64'(i);
      step();
    end
    bus.in_data = 64'h66;
    bus.out_rdy = 1'b1;
    step();
    chk("full_rw_level", 64'(bus.level), 64'd3);
    bus.in_vld = 1'b0;
    repeat (3) step();
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_vld = 1'b1;
      bus.in_data = 64'h300 + 64'(i);
      step();
    end
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = 64'h400 + 64'(i);
      step();
      chk("conc_level", 64'(bus.level), 64'd2);
    end
    bus.in_vld = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.in_vld = 1'b1;
      bus.in_data = 64'h500 + 64'(i);
      step();
    end
    bus.in_vld = 1'b0;
    repeat (2) step();
    chk("wrap_rx", 64'(bus.rx_count), 64'd1);
    chk("wrap_tx", 64'(bus.tx_count), 64'd1);
    chk("err_cleared", 64'(bus.err), 64'd0);
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_vld = 1'b1;
      bus.in_data = 64'h600 + 64'(i);
      step();
    end
    bus.in_vld = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.out_rdy = 1'b1;
    repeat (4) begin
      chk("midrst_out_vld", 64'(bus.out_vld), 64'd0);
      step();
    end
    for (int i = 0; i < 300; i++) begin
      bus.in_vld = 1'($urandom_range(0, 1));
      bus.out_rdy = 1'($urandom_range(0, 2) != 0);
      bus.in_data = {$urandom(), $urandom()};
      step();
    end
    bus.in_vld = 1'b0;
    bus.out_rdy = 1'b1;
    repeat (6) step();
    chk("final_level", 64'(bus.level), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
